fwvip_wb_initiator_core: RTL
============================

Name: fwvip_wb_initiator_core

Overview:
- Wishbone initiator engine. Converts single transactions from an RV request channel into classic single-beat Wishbone cycles, and returns each result on an RV response channel.
- Sits directly upstream of fwvip_wb_target_core: its m* bus outputs drive the target's t* inputs.
- Replaces ad-hoc stimulus masters in benches. Adds a bus timeout so a target that never acknowledges cannot hang the initiator.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- TIMEOUT_CYCLES, 256, maximum cycles in BUS without ack/err before forced error; 0 disables the timeout.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_dat  in  ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8+1  {adr, dat_w, sel, we}; we = bit 0.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid && ready.
- rsp_dat  out  DATA_WIDTH+1  {dat_r, err}; err = bit 0.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid && ready.
- madr  out  ADDR_WIDTH  bus address.
- mdat_w  out  DATA_WIDTH  bus write data.
- mdat_r  in  DATA_WIDTH  bus read data.
- mwe  out  1  write enable.
- mstb  out  1  strobe.
- msel  out  DATA_WIDTH/8  byte selects.
- mack  in  1  acknowledge.
- merr  in  1  error.
- mcyc  out  1  cycle.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - State = IDLE.
  - mcyc, mstb, mwe, rsp_valid = 0.
  - madr, mdat_w, msel, rsp_dat, timeout counter = 0.
  - req_ready = 0 while reset is asserted.
- Reset mid-operation: the bus drops on the next edge; any in-flight transaction and pending response are discarded.
- All outputs are registered, except req_ready, which is combinational: (state == IDLE) && reset.
- IDLE:
  - On req_valid && req_ready, latch the request fields onto madr/mdat_w/msel/mwe.
  - Set mcyc = mstb = 1, clear the counter, go to BUS.
  - The bus is active in the cycle after acceptance.
- BUS:
  - madr/mdat_w/msel/mwe are held stable; mcyc == mstb == 1 throughout.
  - Each cycle with !mack && !merr: counter += 1.
  - If mack || merr is sampled high:
    - mcyc, mstb, mwe <= 0.
    - rsp_dat <= {mack && !merr ? mdat_r : 0, merr}.
    - rsp_valid <= 1; go to RSP.
  - mack && merr together: error wins (err = 1, dat_r = 0).
  - Read data is captured for writes too; it is undefined from the target and passed through as sampled.
  - Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 with no termination:
    - Terminate the bus on that edge.
    - rsp_dat <= {0, 1}; go to RSP.
    - mcyc is therefore high for exactly TIMEOUT_CYCLES cycles.
  - The counter width is sized to hold TIMEOUT_CYCLES and saturates, so there is no wrap.
- RSP:
  - rsp_valid is held with rsp_dat stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE.
  - The next request can be accepted in the cycle after rsp_valid falls; there is no request/response overlap.
- Stray mack/merr in IDLE or RSP is ignored and has no state effect.
- Latency:
  - Zero-wait target (ack asserted combinationally in the first bus cycle): acceptance edge N, bus active N..N+1, rsp_valid high after edge N+1.
  - Each target wait state adds 1 cycle.
- Exactly one outstanding transaction; no pipelined Wishbone mode.
- Wishbone checker rules must hold:
  - mstb implies mcyc.
  - Control signals stable while mstb && !mack && !merr.
  - mcyc drops the cycle after termination.

Test Plan:
- Write, zero-wait target: req {adr=0x10, dat_w=0xDEADBEEF, sel=0xF, we=1} -> one bus cycle with madr=0x10, mdat_w=0xDEADBEEF, msel=0xF, mwe=1; rsp_dat={x,0}; accept-to-rsp_valid = 2 cycles.
- Read, 3 wait states, mdat_r=0x12345678 at ack -> mcyc high 4 cycles; rsp_dat={0x12345678,0}; controls stable throughout.
- Error: target asserts merr (and mack in the same cycle) on a read -> rsp_dat={0,1}; bus released the next cycle.
- Timeout: TIMEOUT_CYCLES=8, target never responds -> mcyc high exactly 8 cycles; rsp_dat={0,1}; req_ready stays 0 until the response is consumed.
- Backpressure: rsp_ready held low 5 cycles after the response -> rsp_valid and rsp_dat stable; req_ready=0; a second request is accepted the cycle after the handshake.
- Reset mid-BUS: reset=0 during wait state 2 -> mcyc/mstb/rsp_valid=0 after the edge; no response issued; the next request works normally.

Source files
------------

// File: rtl/fwvip_wb_initiator_core.sv
// Wishbone initiator: turns ready/valid requests into classic single-beat bus cycles
// and returns each result on a ready/valid response channel. A bus timeout forces an error.
module fwvip_wb_initiator_core #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8:0] req_dat,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  output logic [DATA_WIDTH:0]                       rsp_dat,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [ADDR_WIDTH-1:0]                     madr,
  output logic [DATA_WIDTH-1:0]                     mdat_w,
  input  logic [DATA_WIDTH-1:0]                     mdat_r,
  output logic                                      mwe,
  output logic                                      mstb,
  output logic [DATA_WIDTH/8-1:0]                   msel,
  input  logic                                      mack,
  input  logic                                      merr,
  output logic                                      mcyc
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [ADDR_WIDTH-1:0]   madr_n;
  logic [DATA_WIDTH-1:0]   mdat_w_n;
  logic [SW-1:0]           msel_n;
  logic                    mwe_n, mcyc_n, mstb_n, rsp_valid_n;
  logic [DATA_WIDTH:0]     rsp_dat_n;

  assign req_ready = (state == IDLE) && reset;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    madr_n      = madr;
    mdat_w_n    = mdat_w;
    msel_n      = msel;
    mwe_n       = mwe;
    mcyc_n      = mcyc;
    mstb_n      = mstb;
    rsp_valid_n = rsp_valid;
    rsp_dat_n   = rsp_dat;
    case (state)
      IDLE: begin
        if (req_valid) begin
          {madr_n, mdat_w_n, msel_n, mwe_n} = req_dat;
          mcyc_n  = 1'b1;
          mstb_n  = 1'b1;
          cnt_n   = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        // Error dominates a simultaneous ack; the timeout only fires when the target stays silent.
        if (mack || merr) begin
          mcyc_n      = 1'b0;
          mstb_n      = 1'b0;
          mwe_n       = 1'b0;
          rsp_dat_n   = {(merr ? {DATA_WIDTH{1'b0}} : mdat_r), merr};
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          mcyc_n      = 1'b0;
          mstb_n      = 1'b0;
          mwe_n       = 1'b0;
          rsp_dat_n   = {{DATA_WIDTH{1'b0}}, 1'b1};
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      madr      <= '0;
      mdat_w    <= '0;
      msel      <= '0;
      mwe       <= 1'b0;
      mcyc      <= 1'b0;
      mstb      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      madr      <= madr_n;
      mdat_w    <= mdat_w_n;
      msel      <= msel_n;
      mwe       <= mwe_n;
      mcyc      <= mcyc_n;
      mstb      <= mstb_n;
      rsp_valid <= rsp_valid_n;
      rsp_dat   <= rsp_dat_n;
    end
  end

endmodule
